// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and a constant-safe clog2
package vga_timing_pkg;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_DIV    = 4;
  localparam int DEF_DELAY  = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DELAY-stage shift register (i_d -> o_q) with async active-low reset to RST_VAL
module vga_delay_line #(
  parameter int W = 1,
  parameter int DELAY = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_pipe [DELAY];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DELAY; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  assign o_q = r_pipe[DELAY-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VESA-style timing generator; in clk/reset_n/en, out p_tick/hsync/vsync/video_on/line_start/frame_start/x/y
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int DIV    = DEF_DIV,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int DELAY  = DEF_DELAY,
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP,
  localparam int XW = clog2(H_TOTAL),
  localparam int YW = clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);
  localparam int DW = DIV > 1 ? clog2(DIV) : 1;
  localparam int W = 6 + XW + YW;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT = XW'(H_DISP);
  localparam logic [XW-1:0] HS_LO = XW'(H_DISP + H_FP);
  localparam logic [XW-1:0] HS_HI = XW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT = YW'(V_DISP);
  localparam logic [YW-1:0] VS_LO = YW'(V_DISP + V_FP);
  localparam logic [YW-1:0] VS_HI = YW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam logic [W-1:0] RST_VAL = {1'b0, !HS_ON, !VS_ON, 3'b000, {XW{1'b0}}, {YW{1'b0}}};
  logic [DW-1:0] r_div;
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;
  logic w_tick, w_h_end, w_v_end, w_hsync, w_vsync, w_video_on, w_line_start, w_frame_start;
  logic [W-1:0] w_bundle, w_out;
  always_comb begin
    w_tick = en && r_div == '0;
    w_h_end = r_h == H_LAST;
    w_v_end = r_v == V_LAST;
    w_hsync = (r_h >= HS_LO && r_h <= HS_HI) ? HS_ON : !HS_ON;
    w_vsync = (r_v >= VS_LO && r_v <= VS_HI) ? VS_ON : !VS_ON;
    w_video_on = r_h < H_ACT && r_v < V_ACT;
    w_line_start = w_tick && r_h == '0;
    w_frame_start = w_line_start && r_v == '0;
    w_bundle = {w_tick, w_hsync, w_vsync, w_video_on, w_line_start, w_frame_start, r_h, r_v};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div <= '0;
      r_h <= '0;
      r_v <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_h <= w_h_end ? '0 : r_h + 1'b1;
        if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
      end
    end
  vga_delay_line #(.W(W), .DELAY(DELAY), .RST_VAL(RST_VAL)) u_dly (
    .clk(clk),
    .reset_n(reset_n),
    .i_d(w_bundle),
    .o_q(w_out)
  );
  assign {p_tick, hsync, vsync, video_on, line_start, frame_start, x, y} = w_out;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for three vga_timing_gen configurations
`timescale 1ns/1ps
module tb_vga_timing_gen;
  typedef struct packed {logic pt, hs, vs, vo, ls, fs; logic [15:0] x, y;} bnd_t;
  localparam int HD[3] = '{640, 640, 8};
  localparam int HF[3] = '{16, 16, 1};
  localparam int HS[3] = '{96, 96, 2};
  localparam int HB[3] = '{48, 48, 1};
  localparam int VD[3] = '{480, 480, 4};
  localparam int VF[3] = '{10, 10, 1};
  localparam int VS[3] = '{2, 2, 1};
  localparam int VB[3] = '{33, 33, 1};
  localparam int DV[3] = '{4, 1, 2};
  localparam int DL[3] = '{1, 3, 2};
  localparam int HP[3] = '{0, 0, 1};
  localparam int VP[3] = '{0, 0, 1};
  logic clk = 0;
  always #5 clk = ~clk;
  logic [2:0] rst_n = '0;
  logic [2:0] en = '0;
  logic pt0, hs0, vs0, vo0, ls0, fs0, pt1, hs1, vs1, vo1, ls1, fs1, pt2, hs2, vs2, vo2, ls2, fs2;
  logic [9:0] x0, y0, x1, y1;
  logic [3:0] x2;
  logic [2:0] y2;
  int n_cmp = 0, n_err = 0, cur = 0, mdiv = 0, mh = 0, mv = 0;
  bnd_t sb[$];
  vga_timing_gen u0 (.clk(clk), .reset_n(rst_n[0]), .en(en[0]), .p_tick(pt0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .line_start(ls0), .frame_start(fs0), .x(x0), .y(y0));
  vga_timing_gen #(.DIV(1), .DELAY(3)) u1 (.clk(clk), .reset_n(rst_n[1]), .en(en[1]), .p_tick(pt1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_start(ls1), .frame_start(fs1), .x(x1), .y(y1));
  vga_timing_gen #(.H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DIV(2), .HS_POL(1), .VS_POL(1), .DELAY(2)) u2 (.clk(clk), .reset_n(rst_n[2]), .en(en[2]), .p_tick(pt2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .line_start(ls2), .frame_start(fs2), .x(x2), .y(y2));
  function automatic bnd_t rst_b(int i);
    return {1'b0, HP[i] == 0, VP[i] == 0, 3'b000, 32'd0};
  endfunction
  function automatic bnd_t model_out();
    logic t, sh, sv;
    t = en[cur] && mdiv == 0;
    sh = mh >= HD[cur] + HF[cur] && mh < HD[cur] + HF[cur] + HS[cur];
    sv = mv >= VD[cur] + VF[cur] && mv < VD[cur] + VF[cur] + VS[cur];
    return {t, sh == (HP[cur] != 0), sv == (VP[cur] != 0), mh < HD[cur] && mv < VD[cur],
            t && mh == 0, t && mh == 0 && mv == 0, 16'(mh), 16'(mv)};
  endfunction
  function automatic bnd_t obs();
    case (cur)
      0: return {pt0, hs0, vs0, vo0, ls0, fs0, 16'(x0), 16'(y0)};
      1: return {pt1, hs1, vs1, vo1, ls1, fs1, 16'(x1), 16'(y1)};
      default: return {pt2, hs2, vs2, vo2, ls2, fs2, 16'(x2), 16'(y2)};
    endcase
  endfunction
  task automatic step();
    int ht, vt;
    ht = HD[cur] + HF[cur] + HS[cur] + HB[cur];
    vt = VD[cur] + VF[cur] + VS[cur] + VB[cur];
    sb.push_back(model_out());
    if (en[cur]) begin
      if (mdiv == 0) begin
        if (mh == ht - 1) begin
          mh = 0;
          mv = (mv == vt - 1) ? 0 : mv + 1;
        end else mh++;
      end
      mdiv = (mdiv + 1) % DV[cur];
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic start(int i);
    @(negedge clk);
    rst_n = '0;
    en = '0;
    cur = i;
    mdiv = 0;
    mh = 0;
    mv = 0;
    sb.delete();
    repeat (DL[i] - 1) sb.push_back(rst_b(i));
    @(negedge clk);
    en[i] = 1'b1;
    rst_n[i] = 1'b1;
  endtask
  task automatic test_reset();
    bnd_t o;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      o = obs();
      n_cmp++;
      if (o !== rst_b(i)) begin n_err++; $display("FAIL reset_u%0d: got %h want %h", i, o, rst_b(i)); end
    end
    n_cmp++;
    if ({hs2, vs2} !== 2'b00) begin n_err++; $display("FAIL reset_pol: got hs/vs %b%b want 00", hs2, vs2); end
  endtask
  task automatic test_line();
    bnd_t o, e;
    int ls_n = 0, ls_a = -1, ls_b = -1, fs_n = 0, hs_n = 0, hs_x = -1, vo_n = 0, vo_max = 0;
    start(0);
    for (int i = 0; i < 6400; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL line_bundle c%0d: got %h want %h", i, o, e); end
      if (o.ls) begin ls_n++; if (ls_a < 0) ls_a = i; else ls_b = i; end
      if (o.fs) fs_n++;
      if (o.pt && !o.hs) begin hs_n++; if (hs_x < 0) hs_x = int'(o.x); end
      if (o.pt && o.vo) begin vo_n++; if (int'(o.x) > vo_max) vo_max = int'(o.x); end
    end
    n_cmp++; if (ls_n != 2) begin n_err++; $display("FAIL line_start_count: got %0d want 2", ls_n); end
    n_cmp++; if (ls_b - ls_a != 3200) begin n_err++; $display("FAIL line_period: got %0d want 3200", ls_b - ls_a); end
    n_cmp++; if (fs_n != 1) begin n_err++; $display("FAIL frame_start_count: got %0d want 1", fs_n); end
    n_cmp++; if (hs_n != 192) begin n_err++; $display("FAIL hsync_ticks: got %0d want 192", hs_n); end
    n_cmp++; if (hs_x != 656) begin n_err++; $display("FAIL hsync_first_x: got %0d want 656", hs_x); end
    n_cmp++; if (vo_n != 1280) begin n_err++; $display("FAIL video_ticks: got %0d want 1280", vo_n); end
    n_cmp++; if (vo_max != 639) begin n_err++; $display("FAIL video_max_x: got %0d want 639", vo_max); end
  endtask
  task automatic test_pause();
    bnd_t o, e;
    int hold_bad = 0, nt = 0;
    int xs[2] = '{-1, -1};
    start(0);
    for (int i = 0; i < 1000 && !(mh == 100 && mdiv == 0); i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pause_run c%0d: got %h want %h", i, o, e); end
    end
    n_cmp++;
    if (!(mh == 100 && mdiv == 0)) begin n_err++; $display("FAIL pause_reach: got x %0d want 100", mh); end
    en[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pause_hold c%0d: got %h want %h", i, o, e); end
      if (o.pt || o.x != 100) hold_bad++;
    end
    n_cmp++; if (hold_bad != 0) begin n_err++; $display("FAIL pause_hold_x: got %0d bad cycles want 0", hold_bad); end
    en[0] = 1'b1;
    for (int i = 0; i < 20 && nt < 2; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pause_resume c%0d: got %h want %h", i, o, e); end
      if (o.pt) begin xs[nt] = int'(o.x); nt++; end
    end
    n_cmp++;
    if (xs[0] != 100 || xs[1] != 101) begin n_err++; $display("FAIL pause_resume_x: got %0d,%0d want 100,101", xs[0], xs[1]); end
  endtask
  task automatic test_fast();
    bnd_t o, e;
    int pt_bad = 0, x_bad = 0, al_bad = 0, seen = 0;
    start(1);
    for (int i = 0; i < 900; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL fast_bundle c%0d: got %h want %h", i, o, e); end
      if (o.pt !== (i >= 2)) pt_bad++;
      if (i >= 2 && int'(o.x) != (i - 2) % 800) x_bad++;
      if (i >= 2 && o.x == 656) begin seen++; if (o.hs !== 1'b0 || o.vo !== 1'b0) al_bad++; end
      if (i >= 2 && o.x == 655 && o.hs !== 1'b1) al_bad++;
      if (i >= 2 && o.x == 639 && o.vo !== 1'b1) al_bad++;
    end
    n_cmp++; if (pt_bad != 0) begin n_err++; $display("FAIL fast_ptick: got %0d bad cycles want 0", pt_bad); end
    n_cmp++; if (x_bad != 0) begin n_err++; $display("FAIL fast_x_inc: got %0d bad cycles want 0", x_bad); end
    n_cmp++; if (al_bad != 0 || seen != 1) begin n_err++; $display("FAIL fast_align: got %0d bad, %0d at 656 want 0,1", al_bad, seen); end
  endtask
  task automatic test_midreset();
    bnd_t o, e;
    int fs_at = -1;
    start(1);
    for (int i = 0; i < 2000 && !(mh == 300 && mv == 1); i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midrst_run c%0d: got %h want %h", i, o, e); end
    end
    n_cmp++;
    if (!(mh == 300 && mv == 1)) begin n_err++; $display("FAIL midrst_reach: got (%0d,%0d) want (300,1)", mh, mv); end
    rst_n[1] = 1'b0;
    #1;
    o = obs();
    n_cmp++;
    if (o !== rst_b(1)) begin n_err++; $display("FAIL midrst_async: got %h want %h", o, rst_b(1)); end
    mdiv = 0;
    mh = 0;
    mv = 0;
    sb.delete();
    repeat (DL[1] - 1) sb.push_back(rst_b(1));
    @(posedge clk);
    @(negedge clk);
    o = obs();
    n_cmp++;
    if (o !== rst_b(1)) begin n_err++; $display("FAIL midrst_held: got %h want %h", o, rst_b(1)); end
    rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midrst_restart c%0d: got %h want %h", i, o, e); end
      if (o.fs && fs_at < 0) fs_at = i;
    end
    n_cmp++;
    if (fs_at != DL[1] - 1) begin n_err++; $display("FAIL midrst_frame_start: got cycle %0d want %0d", fs_at, DL[1] - 1); end
  endtask
  task automatic test_small();
    bnd_t o, e;
    int tk = 0, ls_n = 0, fs_n = 0, hs_n = 0, vs_n = 0, vo_n = 0, wr_n = 0, wr_bad = 0, px = -1, py = -1;
    start(2);
    for (int i = 0; i < 504; i++) begin
      step();
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL small_bundle c%0d: got %h want %h", i, o, e); end
      if (o.ls) ls_n++;
      if (o.fs) fs_n++;
      if (o.pt) begin
        tk++;
        if (px == 11 && py == 6) begin wr_n++; if (o.x != 0 || o.y != 0) wr_bad++; end
        px = int'(o.x);
        py = int'(o.y);
        if (o.hs) hs_n++;
        if (o.vs) vs_n++;
        if (o.vo) vo_n++;
      end
    end
    n_cmp++; if (tk != 252) begin n_err++; $display("FAIL small_ticks: got %0d want 252", tk); end
    n_cmp++; if (ls_n != 21) begin n_err++; $display("FAIL small_line_start: got %0d want 21", ls_n); end
    n_cmp++; if (fs_n != 3) begin n_err++; $display("FAIL small_frame_start: got %0d want 3", fs_n); end
    n_cmp++; if (hs_n != 42) begin n_err++; $display("FAIL small_hsync_hi: got %0d want 42", hs_n); end
    n_cmp++; if (vs_n != 36) begin n_err++; $display("FAIL small_vsync_hi: got %0d want 36", vs_n); end
    n_cmp++; if (vo_n != 96) begin n_err++; $display("FAIL small_video: got %0d want 96", vo_n); end
    n_cmp++; if (wr_n != 2 || wr_bad != 0) begin n_err++; $display("FAIL small_wrap: got %0d wraps %0d bad want 2,0", wr_n, wr_bad); end
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_line();
    test_pause();
    test_fast();
    test_midreset();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
